// File: rtl/mux_stim_checker_if.sv
// Purpose : bus between the stimulus checker and the 2:1 mux under test.
// Latency : wires only; the mux returns y_i combinationally.
// Backpres: none; the checker owns pacing, the mux just follows.
interface mux_stim_checker_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic              sel_o;
    logic [DATA_W-1:0] y_i;

    // Checker side: drives the mux inputs and observes its result.
    modport master (
        output a_o,
        output b_o,
        output sel_o,
        input  y_i
    );

    // Mux side: consumes the stimulus and returns the selected operand.
    modport slave (
        input  a_o,
        input  b_o,
        input  sel_o,
        output y_i
    );
endinterface

// File: rtl/mux_stim_checker.sv
// Purpose : LFSR-driven stimulus and self-check for a combinational 2:1 mux.
// Latency : 1 transaction per 2 cycles; NUM_TXN-run reaches done 2*NUM_TXN cycles after start.
// Backpres: none; start_i is ignored while busy, results hold in DONE until restart/reset.
module mux_stim_checker #(
    parameter int          DATA_W  = 8,
    parameter int          NUM_TXN = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    mux_stim_checker_if.master         mux_bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [7:0]                 err_cnt_o,
    output logic [7:0]                 first_err_idx_o
);

    // An all-zero seed would lock the LFSR, so it is swapped for 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  LAST_TXN = 8'(NUM_TXN - 1);
    localparam logic [7:0]  NO_ERR   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_lfsr;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_sel;
    logic [7:0]         r_txn_cnt;
    logic [7:0]         r_err_cnt;
    logic [7:0]         r_first_err;

    logic               w_clear;
    logic               w_drive;
    logic               w_check;
    logic               w_busy;
    logic               w_done;
    logic               w_last;
    logic               w_mismatch;
    logic               w_feedback;
    logic [DATA_W-1:0]  w_expected;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_last     = (r_txn_cnt == LAST_TXN);
    // Outputs were registered a cycle ago, so y_i has settled by CHECK.
    assign w_expected = r_sel ? r_a : r_b;
    assign w_mismatch = (mux_bus.y_i != w_expected);

    // State register; reset returns to IDLE and drops any run in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_drive     = 1'b0;
        w_check     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_busy      = 1'b1;
                w_drive     = 1'b1;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_busy      = 1'b1;
                w_check     = 1'b1;
                w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start_i) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stimulus generation, LFSR stepping and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr      <= SEED_EFF;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= 1'b0;
            r_txn_cnt   <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_first_err <= NO_ERR;
        end else begin
            if (w_clear) begin
                r_txn_cnt   <= 8'd0;
                r_err_cnt   <= 8'd0;
                r_first_err <= NO_ERR;
            end
            if (w_drive) begin
                r_a    <= r_lfsr[DATA_W-1:0];
                r_b    <= r_lfsr[15:16-DATA_W];
                r_sel  <= ^r_lfsr;
                r_lfsr <= {r_lfsr[14:0], w_feedback};
            end
            if (w_check) begin
                if (w_mismatch) begin
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (r_first_err == NO_ERR) begin
                        r_first_err <= r_txn_cnt;
                    end
                end
                if (!w_last) begin
                    r_txn_cnt <= r_txn_cnt + 8'd1;
                end
            end
        end
    end

    assign mux_bus.a_o   = r_a;
    assign mux_bus.b_o   = r_b;
    assign mux_bus.sel_o = r_sel;

    assign busy_o          = w_busy;
    assign done_o          = w_done;
    assign pass_o          = w_done && (r_err_cnt == 8'd0);
    assign err_cnt_o       = r_err_cnt;
    assign first_err_idx_o = r_first_err;

endmodule

// File: tb/tb_mux_stim_checker.sv
// Purpose : directed bench for mux_stim_checker with a behavioural mux on the bus.
// Latency : results sampled on the falling edge, half a cycle after each update.
// Backpres: none; the bench mux answers combinationally every cycle.
module tb_mux_stim_checker;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [7:0] err_cnt_o;
    logic [7:0] first_err_idx_o;
    logic       mux_inv;

    int          n_checks;
    int          n_errs;
    logic [15:0] m_lfsr;
    logic [7:0]  cap_a;
    logic [7:0]  cap_b;
    logic        cap_sel;

    mux_stim_checker_if #(.DATA_W(8)) mux_bus ();

    // Mux stand-in; mux_inv models a part with its select wired backwards.
    assign mux_bus.y_i = mux_inv ? (mux_bus.sel_o ? mux_bus.b_o : mux_bus.a_o)
                                 : (mux_bus.sel_o ? mux_bus.a_o : mux_bus.b_o);

    mux_stim_checker #(
        .DATA_W  (8),
        .NUM_TXN (16),
        .SEED    (16'hACE1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .mux_bus         (mux_bus),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .err_cnt_o       (err_cnt_o),
        .first_err_idx_o (first_err_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy_o),          32'd0);
        chk({tag, "_done"},  32'(done_o),          32'd0);
        chk({tag, "_pass"},  32'(pass_o),          32'd0);
        chk({tag, "_err"},   32'(err_cnt_o),       32'd0);
        chk({tag, "_first"}, 32'(first_err_idx_o), 32'hFF);
        chk({tag, "_a"},     32'(mux_bus.a_o),     32'd0);
        chk({tag, "_b"},     32'(mux_bus.b_o),     32'd0);
        chk({tag, "_sel"},   32'(mux_bus.sel_o),   32'd0);
    endtask

    // One full run: expected counts come from stepping a reference LFSR
    // through the 16 transactions; pulse_at < 0 means no stray start pulse.
    task automatic run_and_check(input string tag, input bit inv, input int pulse_at);
        logic [15:0] q;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic        exp_sel;
        int          exp_err;
        int          exp_first;
        int          n;
        q         = m_lfsr;
        exp_a     = q[7:0];
        exp_b     = q[15:8];
        exp_sel   = ^q;
        exp_err   = 0;
        exp_first = 255;
        for (int t = 0; t < 16; t++) begin
            if (inv && (q[7:0] != q[15:8])) begin
                if (exp_first == 255) exp_first = t;
                exp_err++;
            end
            q = lfsr_step(q);
        end
        m_lfsr  = q;
        mux_inv = inv;

        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, "_busy_on"},   32'(busy_o), 32'd1);
        chk({tag, "_done_drop"}, 32'(done_o), 32'd0);
        chk({tag, "_pass_low"},  32'(pass_o), 32'd0);

        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            if (n == 1) begin
                cap_a   = mux_bus.a_o;
                cap_b   = mux_bus.b_o;
                cap_sel = mux_bus.sel_o;
            end
            start_i = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;

        chk({tag, "_a0"},          32'(cap_a),           32'(exp_a));
        chk({tag, "_b0"},          32'(cap_b),           32'(exp_b));
        chk({tag, "_sel0"},        32'(cap_sel),         32'(exp_sel));
        chk({tag, "_busy_cycles"}, 32'(n),               32'd32);
        chk({tag, "_done"},        32'(done_o),          32'd1);
        chk({tag, "_pass"},        32'(pass_o),          32'(exp_err == 0));
        chk({tag, "_err_cnt"},     32'(err_cnt_o),       32'(exp_err));
        chk({tag, "_first_err"},   32'(first_err_idx_o), 32'(exp_first));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errs   = 0;
        mux_inv  = 1'b0;
        start_i  = 1'b0;
        reset    = 1'b0;
        m_lfsr   = 16'hACE1;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle");

        // Healthy mux: first transaction is E1/AC with sel 0, y = AC.
        run_and_check("run1", 1'b0, -1);
        chk("run1_hand_a",   32'(cap_a),   32'hE1);
        chk("run1_hand_b",   32'(cap_b),   32'hAC);
        chk("run1_hand_sel", 32'(cap_sel), 32'd0);
        chk("run1_hand_y",   32'(cap_sel ? cap_a : cap_b), 32'hAC);

        // Results stay put in DONE without a new start.
        repeat (3) @(negedge clk);
        chk("done_hold",     32'(done_o),    32'd1);
        chk("done_hold_err", 32'(err_cnt_o), 32'd0);
        chk("done_hold_a",   32'(mux_bus.a_o == 8'd0), 32'd0);

        // Restart from DONE with a select-inverted mux; LFSR carries on.
        run_and_check("run2", 1'b1, -1);
        chk("run2_a_not_seed", 32'(cap_a == 8'hE1 && cap_b == 8'hAC), 32'd0);

        // Stray start during transaction 5 must not disturb the run.
        run_and_check("run3", 1'b1, 10);

        // Reset asserted during transaction 7 aborts the run.
        mux_inv = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (n < 14) begin
            @(negedge clk);
            n++;
        end
        chk("abort_busy_before", 32'(busy_o), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("abort");
        reset  = 1'b1;
        m_lfsr = 16'hACE1;
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy_o), 32'd0);

        // Fresh run after reset replays the seed's first transaction.
        run_and_check("run5", 1'b0, -1);
        chk("run5_hand_a",   32'(cap_a),   32'hE1);
        chk("run5_hand_b",   32'(cap_b),   32'hAC);
        chk("run5_hand_sel", 32'(cap_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
